// File: rtl/borrow_look_ahead_subtractor_seq_if.sv
// Handshake and operand bus for borrow_look_ahead_subtractor_seq.
// Carries ovf only when SUB_SIGNED_OVF_EN is defined.
interface borrow_look_ahead_subtractor_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif
endinterface

// File: rtl/borrow_look_ahead_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one look-ahead nibble per cycle.
// Optional signed overflow output enabled by SUB_SIGNED_OVF_EN.
//
// state | meaning
// IDLE  | ready for operands
// CALC  | resolving nibble cnt_q, borrow carried in brw_q
// DONE  | result presented until out_ready
module borrow_look_ahead_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    borrow_look_ahead_subtractor_seq_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [3:0] a_nib, b_nib, g, p, d;
    logic [4:0] br;

    // Nibble look-ahead: every borrow expressed directly from g/p and the registered borrow.
    always_comb begin
        a_nib = a_q[{cnt_q, 2'b00} +: 4];
        b_nib = b_q[{cnt_q, 2'b00} +: 4];
        g     = ~a_nib & b_nib;
        p     = ~(a_nib ^ b_nib);
        br[0] = brw_q;
        br[1] = g[0] | (p[0] & br[0]);
        br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br[0]);
        br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & br[0]);
        br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & br[0]);
        d     = a_nib ^ b_nib ^ br[3:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                diff_d[{cnt_q, 2'b00} +: 4] = d;
                brw_d = br[4];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bout_d  = br[4];
                    ovf_d   = br[3] ^ br[4];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready is gated by rst so nothing looks acceptable while reset is held.
    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_borrow_look_ahead_subtractor_seq.sv
// Directed, table-driven bench for borrow_look_ahead_subtractor_seq (WIDTH=16).
module tb_borrow_look_ahead_subtractor_seq;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    borrow_look_ahead_subtractor_seq_if #(.WIDTH(16)) sub_if ();

    borrow_look_ahead_subtractor_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sub_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int n = 0;
        while (sub_if.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, sub_if.in_ready}, 32'd1);
        sub_if.in_valid = 1'b1;
        sub_if.a        = a;
        sub_if.b        = b;
        sub_if.bin      = bin;
        @(posedge clk);
        #1;
        sub_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (sub_if.out_valid !== 1'b1 && lat < 30);
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input logic bo, input logic ov);
        check({tag, "_diff"}, {16'd0, sub_if.diff}, {16'd0, d});
        check({tag, "_bout"}, {31'd0, sub_if.bout}, {31'd0, bo});
`ifdef SUB_SIGNED_OVF_EN
        check({tag, "_ovf"}, {31'd0, sub_if.ovf}, {31'd0, ov});
`else
        if (ov === 1'bx) $display("unexpected x in ovf expectation for %s", tag);
`endif
    endtask

    initial begin
        int lat;
        int hits;
        logic [15:0] held_diff;
        logic        held_bout;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};

        rst              = 1'b1;
        sub_if.in_valid  = 1'b0;
        sub_if.a         = '0;
        sub_if.b         = '0;
        sub_if.bin       = 1'b0;
        sub_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, sub_if.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, sub_if.out_valid}, 32'd0);
        check_result("rst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, sub_if.in_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), lat, 32'd5);
            check_result($sformatf("v%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov);
            @(negedge clk);
            check($sformatf("v%0d_ready_back", i), {31'd0, sub_if.in_ready}, 32'd1);
            check($sformatf("v%0d_valid_drop", i), {31'd0, sub_if.out_valid}, 32'd0);
        end

        // Backpressure in DONE with in_valid pulses that must be ignored.
        sub_if.out_ready = 1'b0;
        start_op(16'h0300, 16'h0101, 1'b0);
        wait_done(lat);
        check("bp_latency", lat, 32'd5);
        check_result("bp", 16'h01FF, 1'b0, 1'b0);
        held_diff = sub_if.diff;
        held_bout = sub_if.bout;
        for (int k = 0; k < 3; k++) begin
            sub_if.in_valid = 1'b1;
            sub_if.a        = 16'h4444 + 16'(k);
            sub_if.b        = 16'h1111;
            @(negedge clk);
            check("bp_valid_held", {31'd0, sub_if.out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, sub_if.in_ready}, 32'd0);
            check("bp_diff_held", {16'd0, sub_if.diff}, {16'd0, held_diff});
            check("bp_bout_held", {31'd0, sub_if.bout}, {31'd0, held_bout});
        end
        sub_if.in_valid  = 1'b0;
        sub_if.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, sub_if.out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, sub_if.in_ready}, 32'd1);
        check("bp_diff_kept", {16'd0, sub_if.diff}, 32'h01FF);

        // Operand change during CALC must not affect the result.
        start_op(16'h00FF, 16'h000F, 1'b0);
        sub_if.a = 16'hFFFF;
        sub_if.b = 16'h0000;
        wait_done(lat);
        check("chg_latency", lat, 32'd5);
        check_result("chg", 16'h00F0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during the second CALC cycle abandons the operation.
        start_op(16'h5555, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, sub_if.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, sub_if.out_valid}, 32'd0);
        check("midrst_in_ready_back", {31'd0, sub_if.in_ready}, 32'd1);
        check_result("midrst", 16'h0000, 1'b0, 1'b0);
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sub_if.out_valid === 1'b1) hits++;
        end
        check("midrst_no_valid", hits, 32'd0);
        start_op(16'h0010, 16'h0001, 1'b0);
        wait_done(lat);
        check("fresh_latency", lat, 32'd5);
        check_result("fresh", 16'h000F, 1'b0, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
